// File: rtl/multi_digit_timer.sv
// BCD kitchen-timer core: cascaded per-modulus digits counting up or down
// on a tick strobe, with run/pause/expired control and a done pulse.
module multi_digit_timer #(
  parameter int NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX = {4'd9, 4'd9, 4'd5, 4'd9}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    load,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    direction,
  input  logic [4*NUM_DIGITS-1:0] prog_digits,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    expired,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  localparam int W = 4 * NUM_DIGITS;

  state_t         state, state_n;
  logic [W-1:0]   digits_n;
  logic [W-1:0]   step_d;
  logic [W-1:0]   clamp_d;
  logic           cy;
  logic           done_n;
  logic           at_edge;
  logic           nxt_edge;

  always_comb begin
    step_d = digits;
    cy     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cy) begin
        if (direction) begin
          if (digits[4*i +: 4] == DIGIT_MAX[4*i +: 4]) begin
            step_d[4*i +: 4] = 4'd0;
          end else begin
            step_d[4*i +: 4] = digits[4*i +: 4] + 4'd1;
            cy = 1'b0;
          end
        end else begin
          if (digits[4*i +: 4] == 4'd0) begin
            step_d[4*i +: 4] = DIGIT_MAX[4*i +: 4];
          end else begin
            step_d[4*i +: 4] = digits[4*i +: 4] - 4'd1;
            cy = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    clamp_d = prog_digits;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (prog_digits[4*i +: 4] > DIGIT_MAX[4*i +: 4])
        clamp_d[4*i +: 4] = DIGIT_MAX[4*i +: 4];
    end
  end

  // Boundary is all-max when counting up, all-zero when counting down.
  assign at_edge  = direction ? (digits == DIGIT_MAX)
                              : (digits == '0);
  assign nxt_edge = direction ? (step_d == DIGIT_MAX)
                              : (step_d == '0);

  always_comb begin
    state_n  = state;
    digits_n = digits;
    if (load) begin
      digits_n = clamp_d;
      state_n  = IDLE;
    end else if (stop) begin
      if (state == RUN)
        state_n = PAUSE;
    end else if (start) begin
      if ((state == IDLE || state == PAUSE) && !at_edge)
        state_n = RUN;
    end else if (tick && state == RUN) begin
      if (at_edge) begin
        state_n = EXPIRED;
      end else begin
        digits_n = step_d;
        if (nxt_edge)
          state_n = EXPIRED;
      end
    end
    done_n = (state_n == EXPIRED) && (state != EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      digits <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      digits <= digits_n;
      done   <= done_n;
    end
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_multi_digit_timer.sv
// Directed bench for multi_digit_timer: MM:SS countdown, borrow, up
// saturation, pause/resume, clamping, priority and reset.
module tb_multi_digit_timer;

  logic        clk = 1'b0;
  logic        reset, tick, load, start, stop, direction;
  logic [15:0] prog_digits;
  logic [15:0] digits;
  logic        running, expired, done;

  int checks = 0;
  int errors = 0;

  multi_digit_timer dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .load        (load),
    .start       (start),
    .stop        (stop),
    .direction   (direction),
    .prog_digits (prog_digits),
    .digits      (digits),
    .running     (running),
    .expired     (expired),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    prog_digits = v;
    cycle();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_tick(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0;
    stop = 1'b0; direction = 1'b0; prog_digits = '0;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_digits", 32'(digits), 32'h0000);
    chk("rst_running", 32'(running), 0);
    chk("rst_expired", 32'(expired), 0);
    chk("rst_done", 32'(done), 0);

    // countdown 01:30 -> 00:00 in 90 ticks
    do_load(16'h0130);
    do_start();
    chk("cd_running", 32'(running), 1);
    do_tick(89);
    chk("cd_89", 32'(digits), 32'h0001);
    chk("cd_89_done", 32'(done), 0);
    do_tick(1);
    chk("cd_90", 32'(digits), 32'h0000);
    chk("cd_done", 32'(done), 1);
    chk("cd_expired", 32'(expired), 1);
    chk("cd_running0", 32'(running), 0);
    cycle();
    chk("cd_done_1cyc", 32'(done), 0);
    chk("cd_exp_hold", 32'(expired), 1);
    do_tick(3);
    chk("cd_hold", 32'(digits), 32'h0000);

    // borrow chains
    do_load(16'h1000);
    chk("ld_idle", 32'(expired), 0);
    do_start();
    do_tick(1);
    chk("borrow_1000", 32'(digits), 32'h0959);
    do_load(16'h0010);
    chk("ld_running0", 32'(running), 0);
    do_start();
    do_tick(1);
    chk("borrow_0010", 32'(digits), 32'h0009);

    // up count saturates at 99:59
    do_load(16'h9958);
    direction = 1'b1;
    do_start();
    do_tick(1);
    chk("up_9959", 32'(digits), 32'h9959);
    chk("up_done", 32'(done), 1);
    chk("up_expired", 32'(expired), 1);
    do_tick(2);
    chk("up_sat", 32'(digits), 32'h9959);
    chk("up_done_low", 32'(done), 0);

    // start while at all-max counting up is ignored
    do_load(16'h9959);
    do_start();
    chk("up_start_max", 32'(running), 0);

    // pause / resume
    direction = 1'b0;
    do_load(16'h0005);
    do_start();
    do_tick(2);
    chk("pr_0003", 32'(digits), 32'h0003);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("pr_paused", 32'(running), 0);
    do_tick(4);
    chk("pr_hold", 32'(digits), 32'h0003);
    do_start();
    chk("pr_resumed", 32'(running), 1);
    do_tick(2);
    chk("pr_0001", 32'(digits), 32'h0001);
    chk("pr_nodone", 32'(done), 0);
    do_tick(1);
    chk("pr_0000", 32'(digits), 32'h0000);
    chk("pr_done", 32'(done), 1);

    // clamping of out-of-range fields
    do_load(16'h077A);
    chk("clamp", 32'(digits), 32'h0759);

    // load beats tick while running
    do_load(16'h0005);
    do_start();
    load = 1'b1; tick = 1'b1; prog_digits = 16'h0020;
    cycle();
    load = 1'b0; tick = 1'b0;
    chk("ldtick_val", 32'(digits), 32'h0020);
    chk("ldtick_idle", 32'(running), 0);
    do_tick(1);
    chk("idle_tick", 32'(digits), 32'h0020);

    // start on zero counting down stays idle
    do_load(16'h0000);
    do_start();
    chk("zero_start", 32'(running), 0);
    chk("zero_noexp", 32'(expired), 0);

    // direction change mid-run takes effect on next tick
    do_load(16'h0002);
    do_start();
    do_tick(1);
    chk("dir_down", 32'(digits), 32'h0001);
    direction = 1'b1;
    do_tick(1);
    chk("dir_up", 32'(digits), 32'h0002);
    direction = 1'b0;

    // reset mid-run with coincident tick
    do_load(16'h1234);
    do_start();
    do_tick(5);
    chk("rr_1229", 32'(digits), 32'h1229);
    reset = 1'b1; tick = 1'b1;
    cycle();
    reset = 1'b0; tick = 1'b0;
    chk("rr_digits", 32'(digits), 32'h0000);
    chk("rr_running", 32'(running), 0);
    chk("rr_done", 32'(done), 0);
    cycle();
    chk("rr_done_next", 32'(done), 0);
    chk("rr_exp_next", 32'(expired), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
